rom_load_arbiter: RTL and testbench



---
 rtl/rom_load_pkg.sv | 16 +
 rtl/rom_load_fifo.sv | 44 ++++
 rtl/rom_load_arbiter.sv | 159 +++++++++++++++
 tb/tb_rom_load_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_load_pkg.sv
// Shared types for the ROM load arbiter: FSM states, download FIFO entry, reader ids.
package rom_load_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD_CPU, RD_VID} state_t;

  localparam int IOCTL_AW = 25;

  typedef struct packed {
    logic [IOCTL_AW-1:0] addr;
    logic [7:0]          data;
  } fifo_entry_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_VID = 1'b1;

endpackage

// File: rtl/rom_load_fifo.sv
// Small synchronous FIFO with occupancy count; push when full and pop when empty are ignored.
module rom_load_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_sys)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rom_load_arbiter.sv
// Shares one external byte memory between the ROM download stream, the CPU and video.
// Downloads drain through a FIFO first; readers are served round-robin once the core is out of reset.
module rom_load_arbiter
  import rom_load_pkg::*;
#(
  parameter int         MAW        = 22,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ROM_INDEX  = 8'd0
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  input  logic           ioctl_download,
  input  logic [7:0]     ioctl_index,
  input  logic           ioctl_wr,
  input  logic [24:0]    ioctl_addr,
  input  logic [7:0]     ioctl_dout,
  output logic           ioctl_wait,
  input  logic           cpu_req,
  input  logic [MAW-1:0] cpu_addr,
  output logic           cpu_ack,
  output logic [7:0]     cpu_data,
  input  logic           vid_req,
  input  logic [MAW-1:0] vid_addr,
  output logic           vid_ack,
  output logic [7:0]     vid_data,
  output logic           mem_req,
  output logic           mem_we,
  output logic [MAW-1:0] mem_addr,
  output logic [7:0]     mem_wdata,
  input  logic [7:0]     mem_rdata,
  input  logic           mem_ack,
  output logic           game_rst_n,
  output logic           rom_loaded,
  output logic           addr_ovf
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_q, wr_rise, accept, addr_bad, push, pop, full, empty;
  logic [CW-1:0] count, count_nxt;
  fifo_entry_t   fin, fout;
  state_t        state, state_nxt;
  logic          rr_last, wrote_any;
  logic          unused_addr_hi;

  assign wr_rise   = ioctl_wr & ~wr_q;
  assign accept    = wr_rise & ioctl_download & (ioctl_index == ROM_INDEX);
  assign addr_bad  = (ioctl_addr >> MAW) != '0;
  assign push      = accept & ~addr_bad & ~full;
  assign pop       = (state == WR) & mem_ack;
  assign fin       = '{addr: ioctl_addr, data: ioctl_dout};
  assign count_nxt = count + CW'(push) - CW'(pop);
  // Out-of-range bytes never enter the FIFO, so the high address bits are always zero.
  assign unused_addr_hi = &{1'b0, fout.addr[IOCTL_AW-1:MAW]};

  rom_load_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fifo_entry_t))) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (fin),
    .dout    (fout),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  // Pending download bytes always win; readers wait until the core is released.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = WR;
        else if (game_rst_n && !ioctl_download) begin
          if (cpu_req && vid_req) state_nxt = (rr_last == REQ_CPU) ? RD_VID : RD_CPU;
          else if (cpu_req)       state_nxt = RD_CPU;
          else if (vid_req)       state_nxt = RD_VID;
        end
      end
      default: if (mem_ack) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;
      cpu_data  <= '0;
      vid_data  <= '0;
      rr_last   <= REQ_CPU;
    end else begin
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      if (state == IDLE) begin
        case (state_nxt)
          WR: begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= fout.addr[MAW-1:0];
            mem_wdata <= fout.data;
          end
          RD_CPU: begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= cpu_addr;
          end
          RD_VID: begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= vid_addr;
          end
          default: ;
        endcase
      end else if (mem_ack) begin
        mem_req <= 1'b0;
        if (state == RD_CPU) begin
          cpu_ack  <= 1'b1;
          cpu_data <= mem_rdata;
          rr_last  <= REQ_CPU;
        end
        if (state == RD_VID) begin
          vid_ack  <= 1'b1;
          vid_data <= mem_rdata;
          rr_last  <= REQ_VID;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_q       <= 1'b0;
      ioctl_wait <= 1'b0;
      addr_ovf   <= 1'b0;
      game_rst_n <= 1'b0;
      rom_loaded <= 1'b0;
      wrote_any  <= 1'b0;
    end else begin
      wr_q       <= ioctl_wr;
      ioctl_wait <= count_nxt >= CW'(FIFO_DEPTH - 1);
      if (accept && (addr_bad || full)) addr_ovf <= 1'b1;
      if (pop) wrote_any <= 1'b1;
      if (ioctl_download) game_rst_n <= 1'b0;
      else if (!game_rst_n && empty && state == IDLE) begin
        game_rst_n <= 1'b1;
        wrote_any  <= 1'b0;
        if (wrote_any) rom_loaded <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Directed bench: memory responder with programmable ack delay, download driver, reader checks.
module tb_rom_load_arbiter;
  localparam int MAW = 22;

  logic           clk_sys = 1'b0, reset_n = 1'b0;
  logic           ioctl_download = 1'b0, ioctl_wr = 1'b0, ioctl_wait;
  logic [7:0]     ioctl_index = 8'd0, ioctl_dout = 8'd0;
  logic [24:0]    ioctl_addr = '0;
  logic           cpu_req = 1'b0, vid_req = 1'b0, cpu_ack, vid_ack;
  logic [MAW-1:0] cpu_addr = '0, vid_addr = '0, mem_addr;
  logic [7:0]     cpu_data, vid_data, mem_wdata, mem_rdata;
  logic           mem_req, mem_we, mem_ack, game_rst_n, rom_loaded, addr_ovf;

  rom_load_arbiter #(.MAW(MAW), .FIFO_DEPTH(4), .ROM_INDEX(8'd0)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .game_rst_n(game_rst_n), .rom_loaded(rom_loaded), .addr_ovf(addr_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  int             n_chk = 0, n_fail = 0;
  int             cyc = 0, ack_dly = 0, cnt = 0, sent = 0, popped = 0, cpu_bad = 0;
  int             last_wr_cyc = 0, rise_cyc = 0, wait_lvl = -1;
  logic           wait_armed = 1'b0, grst_prev = 1'b0, last_we = 1'b0;
  logic [MAW-1:0] wr_a[$];
  logic [7:0]     wr_d[$];
  logic           ack_who[$];   // 0 = CPU, 1 = VID
  logic [7:0]     ack_dat[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Memory responder and observers, all sampled on the falling edge.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 8'd0;
    forever begin
      @(negedge clk_sys);
      if (mem_ack) begin
        mem_ack = 1'b0;
        if (last_we) popped++;
      end else if (mem_req) begin
        if (cnt >= ack_dly) begin
          mem_ack = 1'b1;
          mem_rdata = mem_addr[7:0] ^ 8'hA5;
          last_we = mem_we;
          cnt = 0;
          if (mem_we) begin
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_wdata);
            last_wr_cyc = cyc + 1;
          end
        end else cnt++;
      end else cnt = 0;
      if (cpu_ack) begin
        ack_who.push_back(1'b0); ack_dat.push_back(cpu_data);
        if (!game_rst_n) cpu_bad++;
      end
      if (vid_ack) begin ack_who.push_back(1'b1); ack_dat.push_back(vid_data); end
      if (game_rst_n && !grst_prev) rise_cyc = cyc;
      grst_prev = game_rst_n;
      if (wait_armed && ioctl_wait) begin wait_lvl = sent - popped; wait_armed = 1'b0; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys); #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int gap);
    int n = 0;
    while (ioctl_wait && n < 300) begin tick(); n++; end
    if (n >= 300) chk("wait_timeout", 32'(ioctl_wait), 0);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(posedge clk_sys); sent++;
    tick(); ioctl_wr = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_grst(input int limit);
    int n = 0;
    while (!game_rst_n && n < limit) begin tick(); n++; end
    chk("grst_rise", 32'(game_rst_n), 1);
  endtask

  task automatic wait_acks(input int num, input int limit, output int n);
    n = 0;
    while (ack_who.size() < num && n < limit) begin tick(); n++; end
    chk("ack_count", ack_who.size(), num);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) tick();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_grst", 32'(game_rst_n), 0);
    chk("rst_loaded", 32'(rom_loaded), 0);
    chk("rst_ovf", 32'(addr_ovf), 0);
    chk("rst_acks", {30'd0, cpu_ack, vid_ack}, 0);
    reset_n = 1'b1;
    tick();
    chk("grst_after_rst", 32'(game_rst_n), 1);

    // Foreign index: everything discarded
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick();
    chk("grst_forced_low", 32'(game_rst_n), 0);
    for (int i = 0; i < 4; i++) send_byte(25'(i), 8'h77, 1);
    ioctl_download = 1'b0;
    wait_grst(50);
    chk("idx1_writes", wr_a.size(), 0);
    chk("idx1_loaded", 32'(rom_loaded), 0);
    ioctl_index = 8'd0;

    // 16-byte load with immediate acks
    ioctl_download = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(25'(i), 8'h10 + 8'(i), 1);
    ioctl_download = 1'b0;
    wait_grst(100);
    chk("load16_writes", wr_a.size(), 16);
    foreach (wr_a[i]) begin
      chk("load16_addr", 32'(wr_a[i]), i);
      chk("load16_data", 32'(wr_d[i]), 32'h10 + i);
    end
    chk("load16_grst_time", rise_cyc, last_wr_cyc + 1);
    chk("load16_loaded", 32'(rom_loaded), 1);
    chk("load16_ovf", 32'(addr_ovf), 0);

    // Slow memory: back-pressure, nothing lost
    ack_dly = 20; wr_a.delete(); wr_d.delete();
    sent = 0; popped = 0; wait_lvl = -1; wait_armed = 1'b1;
    ioctl_download = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(25'h100 + 25'(i), 8'hC0 + 8'(i), 3);
    ioctl_download = 1'b0;
    wait_grst(400);
    chk("slow_wait_level", wait_lvl, 3);
    chk("slow_writes", wr_a.size(), 8);
    foreach (wr_a[i]) begin
      chk("slow_addr", 32'(wr_a[i]), 32'h100 + i);
      chk("slow_data", 32'(wr_d[i]), 32'hC0 + i);
    end
    chk("slow_ovf", 32'(addr_ovf), 0);

    // Address beyond memory: dropped, sticky flag
    ack_dly = 0; wr_a.delete(); wr_d.delete();
    ioctl_download = 1'b1;
    send_byte(25'h400000, 8'hEE, 1);
    ioctl_download = 1'b0;
    wait_grst(50);
    chk("ovf_writes", wr_a.size(), 0);
    chk("ovf_flag", 32'(addr_ovf), 1);
    chk("ovf_loaded_kept", 32'(rom_loaded), 1);

    // Lone video read: latency and data; pointer moves to VID
    ack_who.delete(); ack_dat.delete();
    vid_addr = 22'h33; vid_req = 1'b1;
    wait_acks(1, 50, n);
    vid_req = 1'b0;
    chk("vid_latency", n, 2);
    chk("vid_who", 32'(ack_who[0]), 1);
    chk("vid_data", 32'(ack_dat[0]), 32'h96);
    tick(); tick();

    // Both held: alternate CPU, VID, CPU, VID
    ack_who.delete(); ack_dat.delete();
    cpu_addr = '0; cpu_req = 1'b1; vid_req = 1'b1;
    wait_acks(4, 100, n);
    cpu_req = 1'b0; vid_req = 1'b0;
    repeat (5) tick();
    chk("rr_total", ack_who.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_who", 32'(ack_who[i]), i % 2);
      chk("rr_data", 32'(ack_dat[i]), (i % 2) ? 32'h96 : 32'hA5);
    end

    // Download starts during a video read
    ack_dly = 5; ack_who.delete(); ack_dat.delete(); wr_a.delete(); wr_d.delete(); cpu_bad = 0;
    vid_addr = 22'h44; vid_req = 1'b1;
    n = 0;
    while (!(mem_req && !mem_we) && n < 20) begin tick(); n++; end
    chk("mid_rd_started", 32'(mem_req), 1);
    ioctl_download = 1'b1;
    tick();
    chk("mid_grst_low", 32'(game_rst_n), 0);
    wait_acks(1, 50, n);
    vid_req = 1'b0;
    chk("mid_vid_who", 32'(ack_who[0]), 1);
    chk("mid_vid_data", 32'(ack_dat[0]), 32'hE1);
    cpu_addr = 22'h07; cpu_req = 1'b1;
    send_byte(25'h20, 8'h55, 1);
    send_byte(25'h21, 8'h66, 1);
    ioctl_download = 1'b0;
    wait_grst(100);
    chk("mid_no_grant", ack_who.size(), 1);
    chk("mid_cpu_bad", cpu_bad, 0);
    wait_acks(2, 50, n);
    cpu_req = 1'b0;
    chk("mid_cpu_who", 32'(ack_who[1]), 0);
    chk("mid_cpu_data", 32'(ack_dat[1]), 32'hA2);
    chk("mid_writes", wr_a.size(), 2);
    chk("mid_wr0", {wr_a[0][15:0], wr_d[0]}, 32'h0020_55);
    chk("mid_wr1", {wr_a[1][15:0], wr_d[1]}, 32'h0021_66);

    // Reset in the middle of a write
    ack_dly = 20;
    ioctl_download = 1'b1;
    send_byte(25'h30, 8'h99, 1);
    n = 0;
    while (!(mem_req && mem_we) && n < 20) begin tick(); n++; end
    chk("rstmid_wr_started", 32'(mem_req), 1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_mem_req", 32'(mem_req), 0);
    chk("rstmid_grst", 32'(game_rst_n), 0);
    chk("rstmid_loaded", 32'(rom_loaded), 0);
    ioctl_download = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
